// File: rtl/pe_pkg.sv
// Shared types and constants for the systolic array readout path.
package pe_pkg;

  localparam int unsigned ACC_W = 32;
  localparam int Q8_MAX = 127;
  localparam int Q8_MIN = -128;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

endpackage

// File: rtl/pe_requant.sv
// Combinational requantizer: arithmetic right shift by SHIFT, then saturate
// to signed 8-bit range, sign-extended back to the accumulator width.
module pe_requant
  import pe_pkg::*;
#(
  parameter int unsigned SHIFT = 0
) (
  input  logic signed [ACC_W-1:0] din,
  output logic signed [ACC_W-1:0] dout
);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = din >>> SHIFT;
    dout    = shifted;
    if (shifted > Q8_MAX) begin
      dout = Q8_MAX;
    end else if (shifted < Q8_MIN) begin
      dout = Q8_MIN;
    end
  end

endmodule

// File: rtl/pe_row_drain.sv
// Row drain: captures N PE accumulators in parallel and streams them out
// one word per beat with row/column tags. PE_DRAIN_SAT_EN enables requantize.
module pe_row_drain
  import pe_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned SHIFT = 0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      cap_valid,
  output logic                                      cap_ready,
  input  logic [N*ACC_W-1:0]                        cap_data,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic [ACC_W-1:0]                          m_data,
  output logic [$clog2(N)-1:0]                      m_col,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] m_row,
  output logic                                      m_row_last,
  output logic                                      m_last
);

  localparam int unsigned COL_W = $clog2(N);
  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(N - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  if (N < 2 || ROWS < 1 || SHIFT > 31) begin : g_bad_cfg
    $error("pe_row_drain: unsupported N/ROWS/SHIFT configuration");
  end

  drain_state_t             state;
  logic [N*ACC_W-1:0]       row_buf;
  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic                     draining;
  logic [ACC_W-1:0]         word_raw;
  logic [ACC_W-1:0]         word_post;

  // Capture / beat sequencing; buffer is cleared so reset leaves no stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      row_buf <= '0;
      col     <= '0;
      row     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cap_valid) begin
            row_buf <= cap_data;
            col     <= '0;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (m_ready) begin
            if (col == COL_LAST) begin
              col   <= '0;
              state <= IDLE;
              row   <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign draining = (state == DRAIN);
  assign word_raw = row_buf[ACC_W*int'(col) +: ACC_W];

`ifdef PE_DRAIN_SAT_EN
  pe_requant #(
    .SHIFT(SHIFT)
  ) u_requant (
    .din (word_raw),
    .dout(word_post)
  );
`else
  assign word_post = word_raw;
`endif

  // All outputs decode registered state only; no path from m_ready/cap_valid.
  assign cap_ready  = !draining;
  assign m_valid    = draining;
  assign m_data     = draining ? word_post : '0;
  assign m_col      = col;
  assign m_row      = row;
  assign m_row_last = draining && (col == COL_LAST);
  assign m_last     = m_row_last && (row == ROW_LAST);

endmodule
